// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the Pong game controller.
//   game_state_t  : top-level game phase (NEWGAME, PLAY, NEWBALL, OVER)
//   TIMER_RELOAD  : value the external frame-tick countdown reloads to
//   DEFAULT_BALLS : balls per game when the parameter is not overridden
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } game_state_t;

    localparam logic [6:0] TIMER_RELOAD  = 7'd127;
    localparam int         DEFAULT_BALLS = 3;

    // Next value of one BCD digit; returns 0 after 9.
    function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/pong_score_bcd.sv
// pong_score_bcd: two-digit BCD score counter (00..99, wraps to 00).
// Ports:
//   clk, reset : clock, asynchronous active-high reset (score -> 00)
//   clr        : synchronous clear to 00 (has priority over inc)
//   inc        : add one to the score
//   d1, d0     : tens and units BCD digits
module pong_score_bcd
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (clr) begin
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (inc) begin
            d0 <= bcd_digit_inc(d0);
            // Units rolling over carries into tens; 99 -> 00 falls out of this.
            if (d0 >= 4'd9)
                d1 <= bcd_digit_inc(d1);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-phase sequencer for Pong.
// Optional feature macro: PONG_SCORE_EN (compiles in the BCD score counter;
// when undefined the score outputs are tied to 0 and hit is ignored).
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   btn[1:0]             : debounced paddle buttons ("any" = btn != 0)
//   refr_tick            : one pulse per video frame
//   hit, miss            : ball/paddle event pulses
//   timer_up             : external countdown has reached 0
//   timer_start          : one-cycle reload request to the countdown (Mealy)
//   timer_tick           : countdown decrement strobe (= refr_tick)
//   gra_still            : freeze ball and paddle graphics
//   game_over            : high while in OVER
//   balls_left[1:0]      : balls remaining, not counting the one in play
//   score_d1, score_d0   : tens / units BCD score digits
//   state_dbg            : current FSM state, for observation only
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS = DEFAULT_BALLS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  btn,
    input  logic        refr_tick,
    input  logic        hit,
    input  logic        miss,
    input  logic        timer_up,
    output logic        timer_start,
    output logic        timer_tick,
    output logic        gra_still,
    output logic        game_over,
    output logic [1:0]  balls_left,
    output logic [3:0]  score_d1,
    output logic [3:0]  score_d0,
    output game_state_t state_dbg
);

    localparam logic [1:0] BALLS_FULL  = 2'(BALLS);
    localparam logic [1:0] BALLS_START = 2'(BALLS - 1);

`ifdef PONG_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    game_state_t state, state_next;
    logic [1:0]  balls_next;
    logic        btn_any;
    logic        hit_taken;

    assign btn_any   = (btn != 2'b00);
    // Without a score counter a hit has no effect, so hit+miss acts as a miss.
    assign hit_taken = SCORE_EN && hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NEWGAME;
            balls_left <= BALLS_FULL;
        end else begin
            state      <= state_next;
            balls_left <= balls_next;
        end
    end

    always_comb begin
        state_next  = state;
        balls_next  = balls_left;
        timer_start = 1'b0;
        unique case (state)
            NEWGAME: begin
                if (btn_any) begin
                    state_next = PLAY;
                    balls_next = BALLS_START;
                end
            end
            PLAY: begin
                // A hit in the same cycle wins over the miss.
                if (!hit_taken && miss) begin
                    timer_start = 1'b1;
                    if (balls_left == 2'd0) begin
                        state_next = OVER;
                    end else begin
                        state_next = NEWBALL;
                        balls_next = balls_left - 2'd1;
                    end
                end
            end
            NEWBALL: begin
                // Button must still be held once the relaunch delay expires.
                if (timer_up && btn_any)
                    state_next = PLAY;
            end
            OVER: begin
                if (timer_up) begin
                    state_next = NEWGAME;
                    balls_next = BALLS_FULL;
                end
            end
            default: state_next = NEWGAME;
        endcase
    end

    assign timer_tick = refr_tick;
    assign gra_still  = (state != PLAY);
    assign game_over  = (state == OVER);
    assign state_dbg  = state;

`ifdef PONG_SCORE_EN
    logic score_clr, score_inc;

    // Cleared only on game start so the final score stays visible in OVER.
    assign score_clr = (state == NEWGAME) && btn_any;
    assign score_inc = (state == PLAY) && hit;

    pong_score_bcd u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .d1    (score_d1),
        .d0    (score_d0)
    );
`else
    assign score_d1 = 4'd0;
    assign score_d0 = 4'd0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for pong_game_ctrl.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int BALLS = 3;
`ifdef PONG_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  btn;
    logic        refr_tick, hit, miss, timer_up;
    logic        timer_start, timer_tick, gra_still, game_over;
    logic [1:0]  balls_left;
    logic [3:0]  score_d1, score_d0;
    game_state_t state_dbg;

    always #5 clk = ~clk;

    pong_game_ctrl #(.BALLS(BALLS)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .refr_tick   (refr_tick),
        .hit         (hit),
        .miss        (miss),
        .timer_up    (timer_up),
        .timer_start (timer_start),
        .timer_tick  (timer_tick),
        .gra_still   (gra_still),
        .game_over   (game_over),
        .balls_left  (balls_left),
        .score_d1    (score_d1),
        .score_d0    (score_d0),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // Packing: [15:14] state, [13] timer_start, [12] timer_tick, [11] gra_still,
    //          [10] game_over, [9:8] balls_left, [7:4] tens, [3:0] units
    logic [15:0] exp_q[$];
    event        mon_ev;
    int          checks = 0;
    int          errors = 0;

    // Behavioural reference of the game rules
    game_state_t m_st;
    int          m_balls;
    int          m_score;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = NEWGAME;
        m_balls = BALLS;
        m_score = 0;
    endtask

    // Expected outputs for the current inputs, then wake the monitor.
    task automatic push_now();
        logic [15:0] e;
        logic        ts;
        ts = (m_st == PLAY) && miss && !(SCORE_EN && hit);
        e[15:14] = m_st;
        e[13]    = ts;
        e[12]    = refr_tick;
        e[11]    = (m_st != PLAY);
        e[10]    = (m_st == OVER);
        e[9:8]   = 2'(m_balls);
        e[7:4]   = 4'(m_score / 10);
        e[3:0]   = 4'(m_score % 10);
        exp_q.push_back(e);
        -> mon_ev;
    endtask

    // Rule update applied at the coming clock edge.
    task automatic model_advance();
        case (m_st)
            NEWGAME: if (btn != 2'b00) begin
                m_st = PLAY; m_balls = BALLS - 1; m_score = 0;
            end
            PLAY: begin
                if (SCORE_EN && hit) m_score = (m_score + 1) % 100;
                else if (miss) begin
                    if (m_balls == 0) m_st = OVER;
                    else begin m_st = NEWBALL; m_balls = m_balls - 1; end
                end
            end
            NEWBALL: if (timer_up && btn != 2'b00) m_st = PLAY;
            OVER: if (timer_up) begin m_st = NEWGAME; m_balls = BALLS; end
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [1:0] b, input logic h, input logic m, input logic tu);
        @(negedge clk);
        btn = b; hit = h; miss = m; timer_up = tu;
        refr_tick = 1'($urandom_range(0, 1));
        #1;
        push_now();
        model_advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(mon_ev) begin
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",       int'(state_dbg),   int'(e[15:14]));
            chk("timer_start", int'(timer_start), int'(e[13]));
            chk("timer_tick",  int'(timer_tick),  int'(e[12]));
            chk("gra_still",   int'(gra_still),   int'(e[11]));
            chk("game_over",   int'(game_over),   int'(e[10]));
            chk("balls_left",  int'(balls_left),  int'(e[9:8]));
            chk("score_d1",    int'(score_d1),    int'(e[7:4]));
            chk("score_d0",    int'(score_d0),    int'(e[3:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; btn = 2'b00; refr_tick = 1'b0;
        hit = 1'b0; miss = 1'b0; timer_up = 1'b0;
        model_reset();
        #12;
        push_now();
        chk("reset_balls", int'(balls_left), 3);
        @(negedge clk) reset = 1'b0;

        // Idle in NEWGAME, then start
        idle(3);
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("start_state", int'(state_dbg), int'(PLAY));
        chk("start_balls", int'(balls_left), 2);

        // Score 12, then 99, then wrap
        hits(12);
        idle(1);
        chk("score_12", int'({score_d1, score_d0}), SCORE_EN ? 8'h12 : 0);
        hits(87);
        idle(1);
        chk("score_99", int'({score_d1, score_d0}), SCORE_EN ? 8'h99 : 0);
        hits(1);
        idle(1);
        chk("score_wrap", int'({score_d1, score_d0}), 0);

        // Miss with balls remaining
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("newball_balls", int'(balls_left), 1);
        drive(2'b11, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 1'b1);
        chk("newball_hold", int'(state_dbg), int'(NEWBALL));
        drive(2'b10, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("relaunch", int'(state_dbg), int'(PLAY));

        // Use up the last balls
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        drive(2'b01, 1'b0, 1'b0, 1'b1);
        hits(5);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("over_flag", int'(game_over), 1);
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("over_to_newgame_balls", int'(balls_left), 3);
        chk("score_held", int'({score_d1, score_d0}), SCORE_EN ? 8'h05 : 0);
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("score_cleared", int'({score_d1, score_d0}), 0);

        // Score 37 with one ball left, then async reset between edges
        hits(37);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        drive(2'b01, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("pre_reset_score", int'({score_d1, score_d0}), SCORE_EN ? 8'h37 : 0);
        chk("pre_reset_balls", int'(balls_left), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        push_now();
        chk("async_reset_state", int'(state_dbg), int'(NEWGAME));
        @(negedge clk) reset = 1'b0;

        // Simultaneous hit and miss
        drive(2'b10, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("hit_miss_state", int'(state_dbg), SCORE_EN ? int'(PLAY) : int'(NEWBALL));
        chk("hit_miss_score", int'({score_d1, score_d0}), SCORE_EN ? 8'h01 : 0);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
